// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Dynamic branch predictor plus ID-stage branch resolution.
//   * IF: a PC-indexed table of saturating counters gives a zero-latency
//     taken/not-taken prediction.
//   * ID: the branch outcome is resolved from the forwarded operands, compared
//     with the prediction carried through IF/ID, and a redirect/flush is raised
//     on a mismatch. The counter for the branch PC is trained on the same edge.
//   * Saturating performance counters track resolved branches and mispredicts.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   IF_PC               fetch PC            -> IF_predict_taken
//   ID_valid, ID_stall  qualify resolution of the instruction in ID
//   ID_Branch           branch type (000 none, 001 beq, 010 bne, 011 blez,
//                       100 bgtz, 101 bltz, 110 bgez, 111 reserved = none)
//   ID_PC, ID_predicted PC and carried prediction of the ID instruction
//   ID_rs_data/rt_data  forwarded operands
//   ID_taken            resolved outcome
//   Redirect            misprediction, PC mux takes corrected path
//   RedirectToTarget    1 = branch target, 0 = ID_PC+4
//   Flush_IF_ID         squash wrong-path instruction in IF/ID
//   BranchCount         resolved branches (saturating)
//   MispredictCount     mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int PERF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PC_WIDTH-1:0]   IF_PC,
    output logic                  IF_predict_taken,
    input  logic                  ID_valid,
    input  logic                  ID_stall,
    input  logic [2:0]            ID_Branch,
    input  logic [PC_WIDTH-1:0]   ID_PC,
    input  logic                  ID_predicted,
    input  logic [DATA_WIDTH-1:0] ID_rs_data,
    input  logic [DATA_WIDTH-1:0] ID_rt_data,
    output logic                  ID_taken,
    output logic                  Redirect,
    output logic                  RedirectToTarget,
    output logic                  Flush_IF_ID,
    output logic [PERF_WIDTH-1:0] BranchCount,
    output logic [PERF_WIDTH-1:0] MispredictCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
    // Weakly not-taken: MSB clear, all lower bits set (01 for 2-bit counters).
    localparam logic [CTR_BITS-1:0]   CTR_INIT = CTR_MAX >> 1;
    localparam logic [PERF_WIDTH-1:0] PERF_MAX = {PERF_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLEZ = 3'b011,
        BR_BGTZ = 3'b100,
        BR_BLTZ = 3'b101,
        BR_BGEZ = 3'b110,
        BR_RSVD = 3'b111
    } branch_e;

    logic [CTR_BITS-1:0]   bht_q [ENTRIES];
    logic [CTR_BITS-1:0]   bht_d [ENTRIES];
    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] id_idx;
    logic [CTR_BITS-1:0]   ctr_cur;
    logic [CTR_BITS-1:0]   ctr_upd;
    logic                  rs_neg;
    logic                  rs_zero;
    logic                  br_taken;
    logic                  resolve;
    logic [PERF_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [PERF_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

    // Word-aligned PCs: byte-offset and upper bits do not select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[PC_WIDTH-1:INDEX_BITS+2], IF_PC[1:0],
                              ID_PC[PC_WIDTH-1:INDEX_BITS+2], ID_PC[1:0]};

    assign if_idx = IF_PC[INDEX_BITS+1:2];
    assign id_idx = ID_PC[INDEX_BITS+1:2];

    // Prediction reads the registered table directly: an update in flight on
    // the same index is not bypassed, IF sees it one cycle later.
    assign IF_predict_taken = bht_q[if_idx][CTR_BITS-1];

    // ---------------------------------------------------------------------
    // Branch resolution
    // ---------------------------------------------------------------------
    assign rs_neg  = ID_rs_data[DATA_WIDTH-1];
    assign rs_zero = (ID_rs_data == '0);

    always_comb begin
        br_taken = 1'b0;
        case (ID_Branch)
            BR_BEQ:  br_taken = (ID_rs_data == ID_rt_data);
            BR_BNE:  br_taken = (ID_rs_data != ID_rt_data);
            BR_BLEZ: br_taken = rs_neg | rs_zero;
            BR_BGTZ: br_taken = ~rs_neg & ~rs_zero;
            BR_BLTZ: br_taken = rs_neg;
            BR_BGEZ: br_taken = ~rs_neg;
            default: br_taken = 1'b0;
        endcase
    end

    assign resolve = ID_valid & ~ID_stall &
                     (ID_Branch != BR_NONE) & (ID_Branch != BR_RSVD);

    assign ID_taken         = resolve & br_taken;
    assign Redirect         = resolve & (ID_taken ^ ID_predicted);
    assign RedirectToTarget = ID_taken;
    assign Flush_IF_ID      = Redirect;

    // ---------------------------------------------------------------------
    // BHT training
    // ---------------------------------------------------------------------
    assign ctr_cur = bht_q[id_idx];

    always_comb begin
        ctr_upd = ctr_cur;
        if (br_taken) begin
            if (ctr_cur != CTR_MAX) ctr_upd = ctr_cur + 1'b1;
        end else begin
            if (ctr_cur != '0) ctr_upd = ctr_cur - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_bht_next
            assign bht_d[gi] = (resolve && (id_idx == INDEX_BITS'(gi))) ? ctr_upd : bht_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CTR_INIT;
        end else begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= bht_d[i];
        end
    end

    // ---------------------------------------------------------------------
    // Performance counters (saturate, never wrap)
    // ---------------------------------------------------------------------
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (resolve) begin
            if (branch_cnt_q != PERF_MAX) branch_cnt_d = branch_cnt_q + 1'b1;
            if (Redirect && (mispredict_cnt_q != PERF_MAX))
                mispredict_cnt_d = mispredict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign BranchCount     = branch_cnt_q;
    assign MispredictCount = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// Testbench for branch_predict_unit. A reference model of the counter table
// and perf counters predicts every combinational output; expectations are
// queued as stimulus is driven and popped when the outputs are sampled.
// PERF_WIDTH is reduced to 4 so counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   IF_PC;
    logic          IF_predict_taken;
    logic          ID_valid;
    logic          ID_stall;
    logic [2:0]    ID_Branch;
    logic [31:0]   ID_PC;
    logic          ID_predicted;
    logic [31:0]   ID_rs_data;
    logic [31:0]   ID_rt_data;
    logic          ID_taken;
    logic          Redirect;
    logic          RedirectToTarget;
    logic          Flush_IF_ID;
    logic [PW-1:0] BranchCount;
    logic [PW-1:0] MispredictCount;

    branch_predict_unit #(
        .PC_WIDTH(32), .DATA_WIDTH(32), .INDEX_BITS(6), .CTR_BITS(2), .PERF_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_PC(IF_PC), .IF_predict_taken(IF_predict_taken),
        .ID_valid(ID_valid), .ID_stall(ID_stall), .ID_Branch(ID_Branch),
        .ID_PC(ID_PC), .ID_predicted(ID_predicted),
        .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data),
        .ID_taken(ID_taken), .Redirect(Redirect),
        .RedirectToTarget(RedirectToTarget), .Flush_IF_ID(Flush_IF_ID),
        .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [1:0] m_bht [64];
    int         m_bc, m_mc;
    logic       pend_res, pend_tk, pend_mis;
    logic [5:0] pend_idx;

    // Expected combinational outputs: {taken, redirect, to_target, flush, pred}
    typedef struct {
        string      tag;
        logic [4:0] vec;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    function automatic logic ref_taken(input logic [2:0] br, input logic [31:0] rs,
                                       input logic [31:0] rt);
        int signed s;
        s = int'(rs);
        case (br)
            3'd1: return rs == rt;
            3'd2: return rs != rt;
            3'd3: return s <= 0;
            3'd4: return s > 0;
            3'd5: return s < 0;
            3'd6: return s >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_bc = 0; m_mc = 0; pend_res = 1'b0;
    endtask

    // Drive one ID/IF cycle and queue the outputs the model expects for it.
    task automatic drive(input string tag, input logic v, input logic st, input logic [2:0] br,
                         input logic [31:0] pc, input logic pr, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ifpc);
        logic res, tk, mis;
        exp_t x;
        ID_valid = v; ID_stall = st; ID_Branch = br; ID_PC = pc; ID_predicted = pr;
        ID_rs_data = rs; ID_rt_data = rt; IF_PC = ifpc;
        res = v && !st && (br != 3'd0) && (br != 3'd7);
        tk  = res && ref_taken(br, rs, rt);
        mis = res && (tk != pr);
        x.tag = tag;
        x.vec = {tk, mis, tk, mis, m_bht[ifpc[7:2]][1]};
        sb.push_back(x);
        pend_res = res; pend_tk = tk; pend_mis = mis; pend_idx = pc[7:2];
    endtask

    // Advance one clock, applying the pending update to the model.
    task automatic tick();
        @(posedge clk);
        if (pend_res) begin
            if (pend_tk && m_bht[pend_idx] != 2'b11) m_bht[pend_idx] = m_bht[pend_idx] + 2'b01;
            if (!pend_tk && m_bht[pend_idx] != 2'b00) m_bht[pend_idx] = m_bht[pend_idx] - 2'b01;
            if (m_bc < 15) m_bc++;
            if (pend_mis && m_mc < 15) m_mc++;
        end
        pend_res = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive("reset", 1'b0, 1'b0, 3'd0, 32'h0040_0000, 1'b0, 32'd0, 32'd0, 32'h0040_0000);
        model_reset();
        #1;
        e = sb.pop_front();
        checks++;
        if ({ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken} !== e.vec) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", e.tag,
                     {ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken}, e.vec);
        end
        checks++;
        if (BranchCount !== 4'd0 || MispredictCount !== 4'd0) begin
            errors++;
            $display("FAIL reset counters: got %0d/%0d expected 0/0", BranchCount, MispredictCount);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // beq mispredict, then training to saturation and back down.
    task automatic test_beq_train();
        logic [31:0] rt_tab [7];
        logic [31:0] ifp_tab [7];
        rt_tab  = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd6, 32'd6, 32'd0};
        ifp_tab = '{32'h0040_0000, 32'h0040_0010, 32'h0040_0010, 32'h0040_0010,
                    32'h0040_0010, 32'h0040_0010, 32'h0040_0010};
        for (int i = 0; i < 7; i++) begin
            // last entry is an idle cycle that exposes the final prediction
            drive($sformatf("beq_train[%0d]", i), (i < 6), 1'b0, 3'd1, 32'h0040_0010,
                  m_bht[4][1], 32'd5, rt_tab[i], ifp_tab[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken} !== e.vec) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", e.tag,
                         {ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken}, e.vec);
            end
            tick();
            checks++;
            if (BranchCount !== 4'(m_bc) || MispredictCount !== 4'(m_mc)) begin
                errors++;
                $display("FAIL beq_train[%0d] counters: got %0d/%0d expected %0d/%0d",
                         i, BranchCount, MispredictCount, m_bc, m_mc);
            end
        end
    endtask

    task automatic test_signed_types();
        logic [2:0]  br_tab [6];
        logic [31:0] rs_tab [6];
        br_tab = '{3'd4, 3'd5, 3'd3, 3'd6, 3'd4, 3'd2};
        rs_tab = '{32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'd1, 32'd7};
        for (int i = 0; i < 6; i++) begin
            drive($sformatf("signed[%0d] br=%0d", i, br_tab[i]), 1'b1, 1'b0, br_tab[i],
                  32'h0040_0020 + 32'(4 * i), 1'b0, rs_tab[i], $urandom, 32'h0040_0100);
            #1;
            e = sb.pop_front();
            checks++;
            if ({ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken} !== e.vec) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", e.tag,
                         {ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken}, e.vec);
            end
            tick();
        end
    endtask

    // Taken beq stalled 3 cycles, released, then a not-taken resolve on the
    // same entry: one update leaves 01 (pred 0), repeated updates would not.
    task automatic test_stall();
        int bc0;
        bc0 = m_bc;
        for (int i = 0; i < 6; i++) begin
            drive($sformatf("stall[%0d]", i), (i < 5), (i < 3), 3'd1, 32'h0040_0040, 1'b0,
                  32'd9, (i == 4) ? 32'd8 : 32'd9, 32'h0040_0040);
            #1;
            e = sb.pop_front();
            checks++;
            if ({ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken} !== e.vec) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", e.tag,
                         {ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken}, e.vec);
            end
            tick();
            if (i == 3) begin
                checks++;
                if (BranchCount !== 4'(bc0 + 1)) begin
                    errors++;
                    $display("FAIL stall count: got %0d expected %0d", BranchCount, bc0 + 1);
                end
            end
        end
    endtask

    // Same-index read/update, then reserved type and invalid slot do nothing.
    task automatic test_same_index_and_idle();
        logic       v_tab [5];
        logic [2:0] b_tab [5];
        v_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        b_tab = '{3'd1, 3'd1, 3'd7, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            drive($sformatf("same_idx[%0d]", i), v_tab[i], 1'b0, b_tab[i], 32'h0040_0080,
                  1'b1, 32'd3, 32'd3, 32'h0040_0080);
            #1;
            e = sb.pop_front();
            checks++;
            if ({ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken} !== e.vec) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", e.tag,
                         {ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken}, e.vec);
            end
            tick();
            checks++;
            if (BranchCount !== 4'(m_bc) || MispredictCount !== 4'(m_mc)) begin
                errors++;
                $display("FAIL same_idx[%0d] counters: got %0d/%0d expected %0d/%0d",
                         i, BranchCount, MispredictCount, m_bc, m_mc);
            end
        end
    endtask

    // Reset asserted between clock edges clears state immediately.
    task automatic test_async_reset();
        drive("async_reset", 1'b0, 1'b0, 3'd0, 32'h0040_0000, 1'b0, 32'd0, 32'd0, 32'h0040_0080);
        void'(sb.pop_front());
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (IF_predict_taken !== m_bht[32][1] || BranchCount !== 4'd0 || MispredictCount !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got pred=%b cnt=%0d/%0d expected pred=%b cnt=0/0",
                     IF_predict_taken, BranchCount, MispredictCount, m_bht[32][1]);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Every resolve mispredicts; both counters must stop at 15.
    task automatic test_perf_saturate();
        for (int i = 0; i < 18; i++) begin
            drive($sformatf("perf[%0d]", i), 1'b1, 1'b0, 3'd2, 32'h0040_00C0, 1'b0,
                  32'd1, 32'd2, 32'h0040_00C0);
            #1;
            e = sb.pop_front();
            checks++;
            if ({ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken} !== e.vec) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", e.tag,
                         {ID_taken, Redirect, RedirectToTarget, Flush_IF_ID, IF_predict_taken}, e.vec);
            end
            tick();
        end
        checks++;
        if (BranchCount !== 4'd15 || MispredictCount !== 4'd15) begin
            errors++;
            $display("FAIL perf_saturate: got %0d/%0d expected 15/15", BranchCount, MispredictCount);
        end
    endtask

    initial begin
        rst_n = 1'b0; IF_PC = '0; ID_valid = 1'b0; ID_stall = 1'b0; ID_Branch = '0;
        ID_PC = '0; ID_predicted = 1'b0; ID_rs_data = '0; ID_rt_data = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_beq_train();
        test_signed_types();
        test_stall();
        test_same_index_and_idle();
        test_async_reset();
        test_perf_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
